// File: rtl/sched_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding and
// default frame geometry.
package sched_pkg;

    localparam int FRAME_W_DEF = 5;
    localparam int DRAIN_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is always one-hot; with no request
// pending it points at the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= gnt[1];
        end
    end

    always_comb begin
        gnt = last_reg ? 2'b01 : 2'b10;
        if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Accepts frames from two requesters, serialises each one MSB first into an
// external sequence detector and reports whether the detector matched.
module frame_sched
    import sched_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DRAIN   = DRAIN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_data,
    output logic               req1_ready,
    output logic               det_reset,
    output logic               det_inp,
    input  logic               det_out,
    output logic               res_valid,
    output logic               res_id,
    output logic               res_hit,
    output logic               busy
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [2:0] DRAIN_LAST = (DRAIN > 0) ? 3'(DRAIN - 1) : 3'd0;

    state_t             state_reg;
    state_t             state_next;
    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [2:0]         drain_cnt_reg;
    logic               hit_reg;
    logic               id_reg;
    logic               res_id_reg;
    logic               res_hit_reg;

    logic [1:0]         valid_vec;
    logic [1:0]         ready_vec;
    logic [1:0]         gnt;
    logic               xfer;
    logic [FRAME_W-1:0] sel_data;

    assign valid_vec = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (valid_vec),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Ready is purely combinational so a requester sees acceptance in the
    // same cycle it presents VALID while the scheduler is idle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = !reset && (state_reg == ST_IDLE) && gnt[gi] && valid_vec[gi];
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign xfer       = |ready_vec;
    assign sel_data   = gnt[1] ? req1_data : req0_data;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    state_next = (DRAIN > 0) ? ST_DRAIN : ST_REPORT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            hit_reg       <= 1'b0;
            id_reg        <= 1'b0;
            res_id_reg    <= 1'b0;
            res_hit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (xfer) begin
                        shift_reg <= sel_data;
                        id_reg    <= gnt[1];
                    end
                end
                ST_CLEAR: begin
                    hit_reg       <= 1'b0;
                    bit_cnt_reg   <= '0;
                    drain_cnt_reg <= '0;
                end
                ST_SHIFT: begin
                    shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                    if (bit_cnt_reg != BIT_LAST) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    // The detector output lags its input by a cycle, so the
                    // first shift cycle still reflects the cleared detector.
                    if (bit_cnt_reg != '0) begin
                        hit_reg <= hit_reg | det_out;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    hit_reg       <= hit_reg | det_out;
                end
                ST_REPORT: begin
                    hit_reg     <= hit_reg | det_out;
                    res_id_reg  <= id_reg;
                    res_hit_reg <= hit_reg | det_out;
                end
                default: begin
                    hit_reg <= hit_reg;
                end
            endcase
        end
    end

    always_comb begin
        det_reset = reset || (state_reg == ST_CLEAR);
        det_inp   = 1'b0;
        res_valid = 1'b0;
        res_id    = 1'b0;
        res_hit   = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            det_inp   = (state_reg == ST_SHIFT) && shift_reg[FRAME_W-1];
            res_valid = (state_reg == ST_REPORT);
            busy      = (state_reg != ST_IDLE);
            if (state_reg == ST_REPORT) begin
                res_id  = id_reg;
                res_hit = hit_reg | det_out;
            end else begin
                res_id  = res_id_reg;
                res_hit = res_hit_reg;
            end
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Scoreboard bench for frame_sched: a cycle-indexed reference model predicts
// every output, directed cases plus randomized traffic with injected resets.
module tb_frame_sched;

    localparam int W = 5;
    localparam int D = 1;
    localparam int NMAX = 8192;
    localparam int RAND_CYCLES = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0, det_out = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         ready0, ready1, det_reset, det_inp, res_valid, res_id, res_hit, busy;

    frame_sched #(.FRAME_W(W), .DRAIN(D)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(ready0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(ready1),
        .det_reset(det_reset), .det_inp(det_inp), .det_out(det_out),
        .res_valid(res_valid), .res_id(res_id), .res_hit(res_hit), .busy(busy)
    );

    // Minimal geometry instance: 2-bit frames, no drain.
    logic       b_rst = 1'b1, b_v0 = 1'b0, b_v1 = 1'b0;
    logic [1:0] b_d0 = '0, b_d1 = '0;
    logic       b_ready0, b_ready1, b_det_reset, b_det_inp, b_res_valid, b_res_id, b_res_hit, b_busy;

    frame_sched #(.FRAME_W(2), .DRAIN(0)) dut_b (
        .clk(clk), .reset(b_rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_ready0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_ready1),
        .det_reset(b_det_reset), .det_inp(b_det_inp), .det_out(1'b0),
        .res_valid(b_res_valid), .res_id(b_res_id), .res_hit(b_res_hit), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int hit;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   res_cycles[$];
    bit   plan [NMAX];

    // Reference model: a frame occupies intervals m_e .. m_rep after its transfer edge.
    bit           m_active = 0;
    int           m_last = 1, m_e = 0, m_rep = 0, m_id = 0, m_hit = 0;
    int           m_res_id = 0, m_res_hit = 0;
    logic [W-1:0] m_data = '0;
    bit           acc0, acc1;

    bit mon_en = 0;
    int e_ready0 = 0, e_ready1 = 0, e_busy = 0, e_det_reset = 1, e_det_inp = 0;
    int e_res_id = 0, e_res_hit = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    function automatic int winner();
        if (v0 && v1) return (m_last == 1) ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    task automatic edge_step();
        bit prev_idle;
        int w;
        @(posedge clk);
        cyc++;
        acc0 = 0;
        acc1 = 0;
        if (rst) begin
            m_active  = 0;
            m_last    = 1;
            m_res_id  = 0;
            m_res_hit = 0;
            sb.delete();
        end else begin
            prev_idle = !m_active;
            if (m_active && m_rep == cyc - 1) begin
                m_res_id  = m_id;
                m_res_hit = m_hit;
                m_active  = 0;
            end
            if (prev_idle && (v0 || v1)) begin
                w      = winner();
                m_last = w;
                m_id   = w;
                m_data = w ? d1 : d0;
                m_e    = cyc;
                m_rep  = cyc + W + D + 1;
                m_hit  = 0;
                for (int i = cyc + 2; i <= m_rep; i++) begin
                    if (plan[i]) m_hit = 1;
                end
                sb.push_back('{w, m_hit, m_rep});
                m_active = 1;
                if (w == 1) acc1 = 1; else acc0 = 1;
            end
        end
        #1;
    endtask

    task automatic apply();
        det_out = plan[cyc];
        if (rst) begin
            e_ready0 = 0; e_ready1 = 0; e_busy = 0; e_det_reset = 1;
            e_det_inp = 0; e_res_id = 0; e_res_hit = 0;
        end else begin
            e_busy      = m_active;
            e_ready0    = (!m_active && v0 && winner() == 0) ? 1 : 0;
            e_ready1    = (!m_active && v1 && winner() == 1) ? 1 : 0;
            e_det_reset = (m_active && cyc == m_e) ? 1 : 0;
            e_det_inp   = 0;
            if (m_active && cyc >= m_e + 1 && cyc <= m_e + W) begin
                e_det_inp = m_data[W - 1 - (cyc - m_e - 1)];
            end
            if (m_active && cyc == m_rep) begin
                e_res_id  = m_id;
                e_res_hit = m_hit;
            end else begin
                e_res_id  = m_res_id;
                e_res_hit = m_res_hit;
            end
        end
        mon_en = 1;
    endtask

    task automatic drain_all();
        for (int k = 0; k < 80; k++) begin
            edge_step();
            if (acc0) v0 = 0;
            if (acc1) v1 = 0;
            apply();
            if (!m_active && !v0 && !v1) break;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready0", ready0, e_ready0);
            chk("ready1", ready1, e_ready1);
            chk("busy", busy, e_busy);
            chk("det_reset", det_reset, e_det_reset);
            chk("det_inp", det_inp, e_det_inp);
            chk("res_id", res_id, e_res_id);
            chk("res_hit", res_hit, e_res_hit);
            if (res_valid) begin
                res_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("res_valid_unexpected", res_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_cycle", cyc, mon_e.due);
                    chk("sb_res_id", res_id, mon_e.id);
                    chk("sb_res_hit", res_hit, mon_e.hit);
                    $display("result cyc=%0d id=%0d hit=%0d", cyc, res_id, res_hit);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                mon_e = sb.pop_front();
                chk("res_timeout", cyc, mon_e.due);
            end
        end
    end

    initial begin
        int e_abort;
        int lat;
        for (int i = 0; i < NMAX; i++) plan[i] = 0;

        // Reset held for five cycles.
        for (int n = 0; n < 5; n++) begin
            edge_step();
            rst = 1;
            apply();
        end
        edge_step();
        rst = 0;
        apply();

        // Single frame from requester 0, no detector hit.
        edge_step();
        v0 = 1; d0 = 5'b10001;
        apply();
        drain_all();

        // Requester 1 with a detector pulse in the third shift cycle.
        edge_step();
        v1 = 1; d1 = 5'b10101;
        plan[cyc + 4] = 1;
        apply();
        drain_all();

        // Contention: requester 0 first, requester 1 right after.
        edge_step();
        v0 = 1; d0 = 5'b11000;
        v1 = 1; d1 = 5'b00111;
        apply();
        drain_all();
        if (res_cycles.size() >= 2) begin
            chk("b2b_spacing", res_cycles[res_cycles.size() - 1] - res_cycles[res_cycles.size() - 2], W + D + 3);
        end else begin
            chk("b2b_result_count", res_cycles.size(), 2);
        end

        // Reset during the third shift cycle aborts the frame.
        edge_step();
        v1 = 1; d1 = 5'b11011;
        apply();
        e_abort = cyc + 1;
        for (int k = 0; k < 10 && cyc < e_abort + 3; k++) begin
            edge_step();
            if (acc1) v1 = 0;
            if (cyc == e_abort + 3) rst = 1;
            apply();
        end
        edge_step();
        rst = 0;
        v1 = 1; d1 = 5'b01110;
        apply();
        drain_all();

        // Randomized traffic with occasional abandoned requests and resets.
        for (int i = cyc + 1; i < NMAX; i++) plan[i] = ($urandom_range(5) == 0);
        for (int n = 0; n < RAND_CYCLES; n++) begin
            edge_step();
            if (acc0) v0 = 0;
            if (acc1) v1 = 0;
            if (rst) rst = 0;
            else if ($urandom_range(249) == 0) rst = 1;
            if (!v0) begin
                if ($urandom_range(3) == 0) begin v0 = 1; d0 = W'($urandom); end
            end else if ($urandom_range(19) == 0) begin
                v0 = 0;
            end
            if (!v1) begin
                if ($urandom_range(3) == 0) begin v1 = 1; d1 = W'($urandom); end
            end else if ($urandom_range(19) == 0) begin
                v1 = 0;
            end
            apply();
        end
        v0 = 0; v1 = 0; rst = 0;
        drain_all();
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        // Minimal geometry: latency FRAME_W+DRAIN+2 = 4.
        mon_en = 0;
        @(posedge clk); #1;
        rst = 1;
        b_rst = 0;
        b_v0 = 1; b_d0 = 2'b11;
        @(negedge clk);
        chk("b_ready0", b_ready0, 1);
        chk("b_busy_idle", b_busy, 0);
        @(posedge clk); #1;
        b_v0 = 0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("b_det_reset", b_det_reset, 1);
            if (k == 2 || k == 3) chk("b_det_inp", b_det_inp, 1);
            if (b_res_valid && lat == 0) begin
                lat = k;
                chk("b_res_id", b_res_id, 0);
                chk("b_res_hit", b_res_hit, 0);
                $display("result b cyc_after_xfer=%0d id=%0d hit=%0d", k, b_res_id, b_res_hit);
            end
        end
        chk("b_latency", lat, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter FRAME_W, default 5, SHALL set the frame length in bits (2..16).
REQ-002 Parameter DRAIN, default 1, SHALL set the number of idle-input cycles after the last frame bit before the result is reported (0..7).
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-005 REQ0_VALID / REQ1_VALID  input  1 each  SHALL indicate that requester 0 / 1 holds a frame.
REQ-006 REQ0_DATA / REQ1_DATA  input  FRAME_W each  SHALL carry the frame, which is sent MSB first.
REQ-007 REQ0_READY / REQ1_READY  output  1 each  SHALL indicate that the controller accepts that requester's frame this cycle.
REQ-008 DET_RESET  output  1  SHALL drive the sequence detector's reset.
REQ-009 DET_INP  output  1  SHALL drive the detector's serial input.
REQ-010 DET_OUT  input  1  SHALL carry the detector's registered match output.
REQ-011 RES_VALID  output  1  SHALL pulse for one cycle when a result is available.
REQ-012 RES_ID  output  1  SHALL give the requester index of the reported result.
REQ-013 RES_HIT  output  1  SHALL be 1 if the detector matched anywhere within the reported frame.
REQ-014 BUSY  output  1  SHALL be 1 in every state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, SHIFT, DRAIN and REPORT.
REQ-016 IDLE, no VALID: the FSM SHALL stay in IDLE.
REQ-017 IDLE, any VALID: the arbiter SHALL grant one requester, and a frame transfers when VALID and READY are both high at a rising edge.
REQ-018 On transfer, the frame and ID SHALL be captured and the FSM SHALL go to CLEAR.
REQ-019 READYx SHALL be high only in IDLE, only for the granted requester, and only while its VALID is high; READYx SHALL be combinational from state, grant and VALID.
REQ-020 Arbitration SHALL be round-robin: if both VALIDs are high, the requester not granted last SHALL win.
REQ-021 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-022 A requester SHALL hold VALID and DATA stable until accepted; a VALID dropped before acceptance SHALL be ignored with no side effect.
REQ-023 CLEAR SHALL last exactly 1 cycle with DET_RESET=1 and DET_INP=0, and then go to SHIFT.
REQ-024 SHIFT SHALL last exactly FRAME_W cycles; in cycle k (k=0..FRAME_W-1), DET_INP SHALL be frame bit FRAME_W-1-k, taken from a registered shift register.
REQ-025 After SHIFT, the FSM SHALL go to DRAIN if DRAIN>0, otherwise to REPORT.
REQ-026 DRAIN SHALL last DRAIN cycles with DET_INP=0, and then go to REPORT.
REQ-027 A sticky hit flag SHALL clear in CLEAR.
REQ-028 The hit flag SHALL OR in DET_OUT on every cycle from the second SHIFT cycle through the REPORT cycle inclusive.
REQ-029 In REPORT (1 cycle), RES_VALID SHALL be 1, RES_ID SHALL be the captured ID, and RES_HIT SHALL be the hit flag ORed with the current DET_OUT; the FSM SHALL then go to IDLE.
REQ-030 Latency from the transfer edge to RES_VALID SHALL be FRAME_W+DRAIN+2 cycles (8 at defaults).
REQ-031 Throughput SHALL be one frame per FRAME_W+DRAIN+3 cycles, with back-to-back acceptance in the IDLE cycle that follows REPORT.
REQ-032 RES_ID and RES_HIT SHALL hold their values until the next REPORT.
REQ-033 The bit counter SHALL be ceil(log2(FRAME_W+1)) bits wide and SHALL NOT wrap within a frame.
REQ-034 The drain counter SHALL be 3 bits wide.

Reset
REQ-035 While RESET=1, the FSM SHALL be IDLE, the pointer SHALL be 1, and the counters, hit flag and shift register SHALL be 0.
REQ-036 While RESET=1, the outputs SHALL be READY0/1=0, DET_INP=0, RES_VALID=0, RES_ID=0, RES_HIT=0 and BUSY=0.
REQ-037 DET_RESET SHALL equal RESET OR (state==CLEAR).
REQ-038 A RESET asserted mid-frame SHALL abort the frame with no RES_VALID, and the frame SHALL NOT be replayed.

Structure
REQ-039 Package sched_pkg SHALL hold the state encodings (3-bit) and the FRAME_W/DRAIN defaults.
REQ-040 Sub-module rr_arb2 SHALL contain the 2-way round-robin arbiter: inputs CLK, RESET, REQ[1:0] and an ADVANCE strobe (asserted on transfer); output GNT, which is one-hot.
REQ-041 The detector SHALL be instantiated outside frame_sched; frame_sched SHALL drive only DET_RESET and DET_INP.

Verification
REQ-042 The bench SHALL drive DET_OUT from a stub detector so that hits are controlled directly.
REQ-043 Reset: RESET=1 for 5 cycles -> all outputs 0, DET_RESET=1 and BUSY=0 throughout.
REQ-044 Single frame: REQ0 with DATA=5'b10001 and no stub hit -> DET_INP sequence 1,0,0,0,1, then RES_VALID at edge +8 with RES_ID=0 and RES_HIT=0.
REQ-045 Hit capture: REQ1 with DATA=5'b10101 and the stub pulsing DET_OUT=1 in the 3rd SHIFT cycle -> RES_ID=1 and RES_HIT=1.
REQ-046 Contention: both VALIDs high, DATA0=5'b11000 and DATA1=5'b00111 -> REQ0 served first, then REQ1, with RES_ID sequence 0,1 and the second RES_VALID 9 cycles after the first.
REQ-047 Reset mid-frame: RESET=1 in the 3rd SHIFT cycle -> no RES_VALID; after release the FSM is IDLE and a new REQ1 frame is accepted on its first VALID cycle.
REQ-048 Boundary: FRAME_W=2, DRAIN=0 with DATA=2'b11 -> RES_VALID exactly 4 cycles after the transfer edge.
